// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin share of one simple target bus between N_REQ
// requesters, one outstanding downstream access, watchdog error response.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   up_*            per-requester request pulses in, ready/rvalid pulses out,
//                   shared up_rdata, up_busy = slot occupied
//   dn_*            replayed request out, dn_ready/dn_rvalid/dn_rdata in
//   gnt_id          requester currently granted
//   clr_err         clears sticky err_timeout / err_overrun
module bus_rr_arbiter #(
  parameter int          N_REQ          = 2,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         up_valid,
  input  logic [N_REQ-1:0]         up_write,
  input  logic [N_REQ*32-1:0]      up_addr,
  input  logic [N_REQ*32-1:0]      up_wdata,
  input  logic [N_REQ*4-1:0]       up_wstrb,
  output logic [N_REQ-1:0]         up_ready,
  output logic [N_REQ-1:0]         up_rvalid,
  output logic [31:0]              up_rdata,
  output logic [N_REQ-1:0]         up_busy,
  output logic                     dn_valid,
  output logic                     dn_write,
  output logic [31:0]              dn_addr,
  output logic [31:0]              dn_wdata,
  output logic [3:0]               dn_wstrb,
  input  logic                     dn_ready,
  input  logic                     dn_rvalid,
  input  logic [31:0]              dn_rdata,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  input  logic                     clr_err,
  output logic                     err_timeout,
  output logic [N_REQ-1:0]         err_overrun
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N_REQ-1:0] r_full;
  logic [N_REQ-1:0] r_wr;
  logic [31:0]      r_addr  [N_REQ];
  logic [31:0]      r_wdata [N_REQ];
  logic [3:0]       r_strb  [N_REQ];

  logic [GW-1:0]    r_gnt;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    w_sel;
  logic [GW-1:0]    w_idx;
  logic             w_found;
  logic             w_grant;
  logic             w_resp;
  logic             w_tmo;
  logic             w_done;
  logic [CW-1:0]    r_cnt;

  logic             r_dn_write;
  logic [31:0]      r_dn_addr;
  logic [31:0]      r_dn_wdata;
  logic [3:0]       r_dn_wstrb;
  logic [N_REQ-1:0] r_up_ready;
  logic [N_REQ-1:0] r_up_rvalid;
  logic [31:0]      r_up_rdata;
  logic [N_REQ-1:0] r_ovr;
  logic             r_tmo_err;

  // Scan from the far end toward r_ptr+1 so the nearest full slot
  // after the last grant is the final assignment.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = GW'((int'(r_ptr) + k) % N_REQ);
      if (r_full[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_resp = r_dn_write ? dn_ready : dn_rvalid;
  assign w_tmo  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_done = (r_state == S_WAIT) && (w_resp || w_tmo);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT || w_done) r_cnt <= '0;
    else                                    r_cnt <= r_cnt + 1'b1;
  end

  // A completion always belongs to a full slot, so set and clear
  // never target the same slot on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
      r_ovr  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (up_valid[i] && !r_full[i]) r_full[i] <= 1'b1;
      end
      if (w_done) r_full[r_gnt] <= 1'b0;
      r_ovr <= (up_valid & r_full) | (r_ovr & {N_REQ{~clr_err}});
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (up_valid[i] && !r_full[i]) begin
        r_wr[i]    <= up_write[i];
        r_addr[i]  <= up_addr[32*i +: 32];
        r_wdata[i] <= up_wdata[32*i +: 32];
        r_strb[i]  <= up_wstrb[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_ptr      <= GW'(N_REQ - 1);
      r_dn_write <= 1'b0;
      r_dn_addr  <= '0;
      r_dn_wdata <= '0;
      r_dn_wstrb <= '0;
    end else if (w_grant) begin
      r_gnt      <= w_sel;
      r_ptr      <= w_sel;
      r_dn_write <= r_wr[w_sel];
      r_dn_addr  <= r_addr[w_sel];
      r_dn_wdata <= r_wdata[w_sel];
      r_dn_wstrb <= r_wr[w_sel] ? r_strb[w_sel] : 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_ready  <= '0;
      r_up_rvalid <= '0;
      r_up_rdata  <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_up_ready  <= '0;
      r_up_rvalid <= '0;
      if (w_done) begin
        if (r_dn_write) begin
          r_up_ready[r_gnt] <= 1'b1;
        end else begin
          r_up_rvalid[r_gnt] <= 1'b1;
          r_up_rdata <= w_resp ? dn_rdata : ERR_RDATA;
        end
      end
      r_tmo_err <= (w_done & ~w_resp) | (r_tmo_err & ~clr_err);
    end
  end

  assign dn_valid    = (r_state == S_ISSUE);
  assign dn_write    = r_dn_write;
  assign dn_addr     = r_dn_addr;
  assign dn_wdata    = r_dn_wdata;
  assign dn_wstrb    = r_dn_wstrb;
  assign up_ready    = r_up_ready;
  assign up_rvalid   = r_up_rvalid;
  assign up_rdata    = r_up_rdata;
  assign up_busy     = r_full;
  assign gnt_id      = r_gnt;
  assign err_timeout = r_tmo_err;
  assign err_overrun = r_ovr;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of bus_rr_arbiter.
module tb_bus_rr_arbiter;

  localparam int N  = 3;
  localparam int GW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    up_valid;
  logic [N-1:0]    up_write;
  logic [N*32-1:0] up_addr;
  logic [N*32-1:0] up_wdata;
  logic [N*4-1:0]  up_wstrb;
  logic [N-1:0]    up_ready;
  logic [N-1:0]    up_rvalid;
  logic [31:0]     up_rdata;
  logic [N-1:0]    up_busy;
  logic            dn_valid;
  logic            dn_write;
  logic [31:0]     dn_addr;
  logic [31:0]     dn_wdata;
  logic [3:0]      dn_wstrb;
  logic            dn_ready;
  logic            dn_rvalid;
  logic [31:0]     dn_rdata;
  logic [GW-1:0]   gnt_id;
  logic            clr_err;
  logic            err_timeout;
  logic [N-1:0]    err_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  bus_rr_arbiter #(
    .N_REQ(N),
    .TIMEOUT_CYCLES(64),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_write(up_write),
    .up_addr(up_addr), .up_wdata(up_wdata),
    .up_wstrb(up_wstrb), .up_ready(up_ready),
    .up_rvalid(up_rvalid), .up_rdata(up_rdata),
    .up_busy(up_busy), .dn_valid(dn_valid),
    .dn_write(dn_write), .dn_addr(dn_addr),
    .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb),
    .dn_ready(dn_ready), .dn_rvalid(dn_rvalid),
    .dn_rdata(dn_rdata), .gnt_id(gnt_id),
    .clr_err(clr_err), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit w,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] s);
    up_valid[i]          = 1'b1;
    up_write[i]          = w;
    up_addr[32*i +: 32]  = a;
    up_wdata[32*i +: 32] = d;
    up_wstrb[4*i +: 4]   = s;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    up_valid  = '0;
    dn_ready  = 1'b0;
    dn_rvalid = 1'b0;
    clr_err   = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    up_write = '0;
    up_addr  = '0;
    up_wdata = '0;
    up_wstrb = '0;
    dn_rdata = '0;
    do_reset;
    n_tests++;
    if ({up_ready, up_rvalid, up_rdata, up_busy, dn_valid,
         dn_write, dn_addr, dn_wdata, dn_wstrb, gnt_id,
         err_timeout, err_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero busy=%b dn_valid=%b", up_busy, dn_valid);
    end
  endtask

  task automatic test_single_write;
    do_reset;
    set_req(0, 1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF);
    tick;
    up_valid = '0;
    n_tests++;
    if (up_busy !== 3'b001 || dn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_cycle1: busy=%b dn_valid=%b want 001/0", up_busy, dn_valid);
    end
    tick;
    n_tests++;
    if (dn_valid !== 1'b1 || dn_write !== 1'b1 || gnt_id !== GW'(0)) begin
      n_fail++;
      $display("FAIL wr_issue: valid=%b write=%b gnt=%0d want 1/1/0", dn_valid, dn_write, gnt_id);
    end
    n_tests++;
    if (dn_addr !== 32'h4000_0010 || dn_wdata !== 32'h1234_5678 || dn_wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_payload: addr=%h data=%h strb=%h", dn_addr, dn_wdata, dn_wstrb);
    end
    tick;
    dn_ready = 1'b1;
    n_tests++;
    if (dn_valid !== 1'b0 || up_ready !== '0) begin
      n_fail++;
      $display("FAIL wr_wait: dn_valid=%b up_ready=%b want 0/000", dn_valid, up_ready);
    end
    tick;
    dn_ready = 1'b0;
    n_tests++;
    if (up_ready !== 3'b001 || up_busy !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_resp: up_ready=%b busy=%b want 001/000", up_ready, up_busy);
    end
    tick;
    n_tests++;
    if (up_ready !== '0) begin
      n_fail++;
      $display("FAIL wr_pulse: up_ready=%b want 000", up_ready);
    end
  endtask

  task automatic test_single_read;
    do_reset;
    set_req(1, 1'b0, 32'h4000_0020, 32'h5555_5555, 4'hA);
    tick;
    up_valid = '0;
    tick;
    n_tests++;
    if (dn_valid !== 1'b1 || dn_write !== 1'b0 || dn_wstrb !== 4'h0 || gnt_id !== GW'(1)) begin
      n_fail++;
      $display("FAIL rd_issue: valid=%b write=%b strb=%h gnt=%0d", dn_valid, dn_write, dn_wstrb, gnt_id);
    end
    tick;
    dn_rvalid = 1'b1;
    dn_rdata  = 32'hCAFE_0001;
    n_tests++;
    if (dn_addr !== 32'h4000_0020 || dn_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL rd_hold: addr=%h strb=%h want 40000020/0", dn_addr, dn_wstrb);
    end
    tick;
    dn_rvalid = 1'b0;
    dn_rdata  = 32'h0;
    n_tests++;
    if (up_rvalid !== 3'b010 || up_rdata !== 32'hCAFE_0001 || up_ready !== '0) begin
      n_fail++;
      $display("FAIL rd_resp: rvalid=%b rdata=%h want 010/cafe0001", up_rvalid, up_rdata);
    end
    tick;
    n_tests++;
    if (up_rvalid !== '0 || up_rdata !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL rd_hold_data: rvalid=%b rdata=%h", up_rvalid, up_rdata);
    end
  endtask

  task automatic test_contention;
    int n;
    int rem[2];
    bit resp_next;
    do_reset;
    set_req(0, 1'b1, 32'h100, 32'hA000_0000, 4'hF);
    set_req(1, 1'b1, 32'h200, 32'hB000_0000, 4'hF);
    rem[0] = 2;
    rem[1] = 2;
    n = 0;
    resp_next = 1'b0;
    for (int c = 1; c < 200 && n < 6; c++) begin
      tick;
      up_valid  = '0;
      dn_ready  = resp_next;
      resp_next = 1'b0;
      if (dn_valid === 1'b1) begin
        n_tests++;
        if (gnt_id !== GW'(n % 2)) begin
          n_fail++;
          $display("FAIL contention_order: grant %0d is %0d want %0d", n, gnt_id, n % 2);
        end
        n++;
        resp_next = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (up_ready[i] === 1'b1 && rem[i] > 0) begin
          set_req(i, 1'b1, 32'h100 * (i + 1), 32'(c), 4'hF);
          rem[i]--;
        end
      end
    end
    n_tests++;
    if (n != 6) begin
      n_fail++;
      $display("FAIL contention_count: grants=%0d want 6", n);
    end
  endtask

  task automatic test_overrun;
    bit seen;
    do_reset;
    set_req(0, 1'b1, 32'h0000_0100, 32'h0000_AAAA, 4'hF);
    tick;
    set_req(0, 1'b1, 32'h0000_0200, 32'h0000_BBBB, 4'hF);
    tick;
    n_tests++;
    if (err_overrun !== 3'b001 || dn_valid !== 1'b1 || dn_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL ovr_set: ovr=%b valid=%b addr=%h", err_overrun, dn_valid, dn_addr);
    end
    set_req(0, 1'b1, 32'h0000_0300, 32'h0000_CCCC, 4'hF);
    clr_err = 1'b1;
    tick;
    up_valid = '0;
    clr_err  = 1'b0;
    dn_ready = 1'b1;
    n_tests++;
    if (err_overrun !== 3'b001) begin
      n_fail++;
      $display("FAIL ovr_set_wins: ovr=%b want 001", err_overrun);
    end
    tick;
    dn_ready = 1'b0;
    n_tests++;
    if (up_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL ovr_first_resp: up_ready=%b want 001", up_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (dn_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL ovr_dropped: dropped request reached dn (1) want 0");
    end
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    n_tests++;
    if (err_overrun !== '0) begin
      n_fail++;
      $display("FAIL ovr_clear: ovr=%b want 000", err_overrun);
    end
  endtask

  task automatic test_timeout;
    int got;
    int n_rv;
    logic [N-1:0] rv_vec;
    logic [31:0] rv_data;
    logic tmo;
    do_reset;
    set_req(0, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
    got  = -1;
    n_rv = 0;
    rv_vec  = '0;
    rv_data = '0;
    tmo = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      tick;
      up_valid  = '0;
      dn_rvalid = (c == 68);
      dn_rdata  = (c == 68) ? 32'h1111_1111 : 32'h0;
      if (up_rvalid !== '0) begin
        n_rv++;
        if (got < 0) begin
          got     = c;
          rv_vec  = up_rvalid;
          rv_data = up_rdata;
          tmo     = err_timeout;
        end
      end
    end
    n_tests++;
    if (got != 67) begin
      n_fail++;
      $display("FAIL tmo_cycle: response cycle %0d want 67", got);
    end
    n_tests++;
    if (rv_vec !== 3'b001 || rv_data !== 32'hDEAD_BEEF || tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_resp: rvalid=%b rdata=%h err=%b", rv_vec, rv_data, tmo);
    end
    n_tests++;
    if (n_rv != 1 || up_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL tmo_late: pulses=%0d rdata=%h want 1/deadbeef", n_rv, up_rdata);
    end
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    n_tests++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: err_timeout=%b want 0", err_timeout);
    end
  endtask

  task automatic test_reset_in_wait;
    bit seen;
    do_reset;
    set_req(0, 1'b1, 32'h0000_0600, 32'h0000_1111, 4'hF);
    tick;
    up_valid = '0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if ({up_ready, up_rvalid, up_rdata, up_busy, dn_valid,
         dn_write, dn_addr, dn_wdata, dn_wstrb, gnt_id,
         err_timeout, err_overrun} !== '0) begin
      n_fail++;
      $display("FAIL rstwait_outputs: busy=%b dn_addr=%h want 0", up_busy, dn_addr);
    end
    dn_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      dn_ready = 1'b0;
      if (up_ready !== '0 || up_rvalid !== '0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstwait_silent: up response seen (1) want 0");
    end
    set_req(0, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    tick;
    up_valid = '0;
    tick;
    n_tests++;
    if (dn_valid !== 1'b1 || dn_addr !== 32'h700 || gnt_id !== GW'(0)) begin
      n_fail++;
      $display("FAIL rstwait_next_issue: valid=%b addr=%h gnt=%0d", dn_valid, dn_addr, gnt_id);
    end
    tick;
    dn_rvalid = 1'b1;
    dn_rdata  = 32'h0BAD_F00D;
    tick;
    dn_rvalid = 1'b0;
    n_tests++;
    if (up_rvalid !== 3'b001 || up_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rstwait_next_resp: rvalid=%b rdata=%h", up_rvalid, up_rdata);
    end
  endtask

  // Model: per-requester pending request with its pulse cycle; a grant
  // observed at cycle c serves the first pending requester after the
  // previous grant whose pulse was at least two cycles earlier.
  task automatic test_random;
    bit          pend[N];
    bit          pw[N];
    logic [31:0] pa[N];
    logic [31:0] pd[N];
    logic [3:0]  ps[N];
    int          pc[N];
    logic [N-1:0] ovr_exp;
    logic [N-1:0] busy_exp;
    logic [N-1:0] onehot;
    int last, g, eg, rc, iss_c, idx;
    bit infl;
    logic [31:0] rd;
    do_reset;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pc[i]   = 0;
    end
    ovr_exp = '0;
    last = N - 1;
    g = 0;
    rc = -10;
    iss_c = -10;
    infl = 1'b0;
    rd = '0;
    for (int c = 0; c < 600; c++) begin
      if (dn_valid === 1'b1 && infl) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_overlap: dn_valid at cycle %0d while busy", c);
      end
      onehot = '0;
      if (infl && c == rc + 1) begin
        onehot[g] = 1'b1;
        n_tests++;
        if (pw[g] && (up_ready !== onehot || up_rvalid !== '0)) begin
          n_fail++;
          $display("FAIL rnd_wresp: cyc %0d ready=%b rvalid=%b want %b", c, up_ready, up_rvalid, onehot);
        end
        if (!pw[g] && (up_rvalid !== onehot || up_ready !== '0 || up_rdata !== rd)) begin
          n_fail++;
          $display("FAIL rnd_rresp: cyc %0d rvalid=%b rdata=%h want %b/%h", c, up_rvalid, up_rdata, onehot, rd);
        end
        pend[g] = 1'b0;
        infl = 1'b0;
      end else begin
        n_tests++;
        if (up_ready !== '0 || up_rvalid !== '0) begin
          n_fail++;
          $display("FAIL rnd_spurious: cyc %0d ready=%b rvalid=%b want 0", c, up_ready, up_rvalid);
        end
      end
      if (dn_valid === 1'b1 && !infl) begin
        eg = -1;
        for (int k = N; k >= 1; k--) begin
          idx = (last + k) % N;
          if (pend[idx] && pc[idx] <= c - 2) eg = idx;
        end
        n_tests++;
        if (eg < 0) begin
          n_fail++;
          $display("FAIL rnd_grant: cyc %0d unexpected dn_valid gnt=%0d", c, gnt_id);
        end else begin
          if (gnt_id !== GW'(eg) || dn_write !== pw[eg] || dn_addr !== pa[eg] ||
              dn_wdata !== pd[eg] || dn_wstrb !== (pw[eg] ? ps[eg] : 4'h0)) begin
            n_fail++;
            $display("FAIL rnd_grant: cyc %0d gnt=%0d addr=%h data=%h want %0d/%h/%h",
                     c, gnt_id, dn_addr, dn_wdata, eg, pa[eg], pd[eg]);
          end
          g = eg;
          last = eg;
          infl = 1'b1;
          iss_c = c;
          rc = c + 1 + int'($urandom_range(0, 3));
          rd = $urandom;
        end
      end
      for (int i = 0; i < N; i++) busy_exp[i] = pend[i] && pc[i] < c;
      n_tests++;
      if (up_busy !== busy_exp || err_overrun !== ovr_exp) begin
        n_fail++;
        $display("FAIL rnd_status: cyc %0d busy=%b ovr=%b want %b/%b", c, up_busy, err_overrun, busy_exp, ovr_exp);
      end
      up_valid  = '0;
      dn_ready  = 1'b0;
      dn_rvalid = 1'b0;
      dn_rdata  = $urandom;
      if (infl && c == rc) begin
        if (pw[g]) dn_ready = 1'b1;
        else begin
          dn_rvalid = 1'b1;
          dn_rdata  = rd;
        end
      end else if ((!infl || c == iss_c) && $urandom_range(0, 5) == 0) begin
        dn_ready  = 1'b1;
        dn_rvalid = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pc[i]   = c;
          pw[i]   = 1'($urandom_range(0, 1));
          pa[i]   = $urandom;
          pd[i]   = $urandom;
          ps[i]   = 4'($urandom);
          set_req(i, pw[i], pa[i], pd[i], ps[i]);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          ovr_exp[i] = 1'b1;
          set_req(i, 1'b1, $urandom, $urandom, 4'hF);
        end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_contention;
    test_overrun;
    test_timeout;
    test_reset_in_wait;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Shares one bus_simple_if-style target bus between N_REQ requesters (e.g. TB/JTAG master, DMA, CPU). Each requester issues one-cycle valid pulses and waits for m_ready (write) or m_rvalid (read). The block captures each pulse in a per-requester slot, grants in round-robin order, replays the request downstream and routes the response back. A watchdog synthesizes an error response if the target never answers.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 64, WAIT cycles before synthetic error response (>=2)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
up_valid  in  N_REQ  per-requester request pulse
up_write  in  N_REQ  1=write, 0=read
up_addr  in  N_REQ*32  request address, requester i at [32i+31:32i]
up_wdata  in  N_REQ*32  write data
up_wstrb  in  N_REQ*4  byte strobes
up_ready  out  N_REQ  write-complete pulse
up_rvalid  out  N_REQ  read-data-valid pulse
up_rdata  out  32  read data, shared, valid with up_rvalid
up_busy  out  N_REQ  slot i occupied
dn_valid  out  1  downstream request pulse
dn_write  out  1  downstream write
dn_addr  out  32  downstream address
dn_wdata  out  32  downstream write data
dn_wstrb  out  4  downstream strobes
dn_ready  in  1  downstream write complete
dn_rvalid  in  1  downstream read valid
dn_rdata  in  32  downstream read data
gnt_id  out  $clog2(N_REQ)  requester currently granted
clr_err  in  1  clears sticky errors
err_timeout  out  1  sticky: a timeout occurred
err_overrun  out  N_REQ  sticky: up_valid while slot i full

Behaviour:
- Reset (clk edge with rst=1): all slots empty; FSM=IDLE; rr pointer=N_REQ-1 (requester 0 wins first); all outputs 0; timeout counter 0. Reset mid-transaction aborts it silently, with no up-side response.
- Capture: up_valid[i]=1 with slot i empty -> edge stores write/addr/wdata/wstrb, up_busy[i]=1 next cycle. With slot full -> request dropped, err_overrun[i] set.
- FSM IDLE: any slot full -> choose first full slot scanning ptr+1, ptr+2, ... (mod N_REQ); register gnt_id, ptr<=gnt; go ISSUE. Slot filled this cycle is not visible until the next cycle.
- ISSUE (exactly 1 cycle): dn_valid=1; dn_write/addr/wdata from slot; dn_wstrb=slot strobe on writes, 4'h0 on reads. Go WAIT. dn_addr/dn_write/dn_wdata/dn_wstrb held stable through WAIT.
- WAIT: counter increments each cycle.
  - Write and dn_ready=1 -> next cycle up_ready[gnt]=1 for 1 cycle.
  - Read and dn_rvalid=1 -> next cycle up_rvalid[gnt]=1, up_rdata=dn_rdata for 1 cycle.
  - Either completion empties the slot, returns to IDLE and clears the counter.
  - Counter reaches TIMEOUT_CYCLES-1 with no response -> identical synthetic completion (reads: up_rdata=ERR_RDATA), err_timeout=1.
- dn_ready/dn_rvalid outside WAIT are ignored (late responses after a timeout are discarded).
- Min latency: up_valid cycle 0 -> dn_valid cycle 2 -> target response cycle 3 -> up response cycle 4. New up_valid accepted from the cycle up response is high.
- up_rdata holds its last value when up_rvalid=0.
- Back-to-back: after a completion the next grant is issued 2 cycles later (IDLE, ISSUE).
- clr_err=1 clears sticky bits. A simultaneous set wins.
- Only one outstanding downstream transaction at any time.

Test Plan:
- Single write: req0 writes 0x1234_5678 to 0x4000_0010, wstrb F; target answers dn_ready 1 cycle after dn_valid -> dn_valid in cycle 2, up_ready[0] in cycle 4, up_busy[0] low in cycle 4.
- Single read: req1 reads 0x4000_0020; target returns 0xCAFE_0001 -> up_rvalid[1]=1 with up_rdata=0xCAFE_0001, dn_wstrb=0 during the transaction.
- Contention: req0 and req1 pulse in the same cycle, each repeating immediately after its response, for 6 transactions -> grant order 0,1,0,1,0,1, with no requester starved.
- Overrun: req0 pulses twice while slot 0 full -> second request never reaches dn, err_overrun[0]=1; clr_err clears it.
- Timeout: target never responds to read at 0x5000_0000 -> after 64 WAIT cycles up_rvalid[0]=1 with up_rdata=0xDEAD_BEEF, err_timeout=1. A late dn_rvalid arriving in IDLE is ignored.
- Reset in WAIT: rst asserted for 1 cycle -> no up response, all outputs 0, next request from requester 0 is served normally.
